// File: rtl/pi_txn_queue.sv
// rtl/pi_txn_queue.sv - Pi GPIO register front end with command FIFO to the 68K bus FSM
//
// Ports:
//   c200m, rst           clock (rising edge) and synchronous active-high reset
//   PI_A, PI_RD, PI_WR   Pi register select and asynchronous read/write strobes
//   PI_D_in/out/oe       Pi data bus in, out value and drive enable
//   PI_TXN_IN_PROGRESS   queue non-empty, read pending or bus busy (registered)
//   ipl                  interrupt level reported in STATUS
//   cmd_*                FIFO head toward the bus FSM, valid/ready handshake
//   bus_busy             bus FSM mid-cycle
//   rsp_*                bus cycle completion pulse, read data, bus error
//   ctrl_reg             last value written to STATUS (bit1 releases 68K reset)

module pi_txn_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic        c200m,
  input  logic        rst,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_in,
  output logic [15:0] PI_D_out,
  output logic        PI_D_oe,
  output logic        PI_TXN_IN_PROGRESS,
  input  logic [2:0]  ipl,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [22:0] cmd_addr,
  output logic [15:0] cmd_data,
  output logic        cmd_rw,
  output logic        cmd_uds_n,
  output logic        cmd_lds_n,
  output logic [2:0]  cmd_fc,
  input  logic        bus_busy,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_data,
  input  logic        rsp_berr,
  output logic [15:0] ctrl_reg
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } cmd_t;

  // Strobe synchronisers: [0] is the first flop, [1] the second.
  logic [1:0] wr_sync;
  logic [1:0] rd_sync;
  logic       wr_rise_q;
  logic       rd_fall_q;

  // Staging registers assembled across DATA / ADDR_LO writes.
  logic [15:0] wdata;
  logic [14:0] addr_lo;
  logic        a0;

  // FIFO
  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  cmd_t             head;
  cmd_t             new_cmd;

  logic        rd_pending;
  logic [15:0] rd_data;
  logic        berr_sticky;
  logic        ovf_sticky;
  logic        txn_q;

  logic        full;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        wr_data_sel;
  logic        wr_lo_sel;
  logic        wr_status_sel;
  logic        sticky_clr;
  logic        berr_set;
  logic        ovf_set;
  logic [15:0] status_word;

  // Decode of the registered write pulse; the Pi holds PI_A/PI_D_in
  // stable for the whole strobe, so raw inputs are safe to use here.
  assign wr_data_sel   = wr_rise_q & (PI_A == REG_DATA);
  assign wr_lo_sel     = wr_rise_q & (PI_A == REG_ADDR_LO);
  assign push_req      = wr_rise_q & (PI_A == REG_ADDR_HI);
  assign wr_status_sel = wr_rise_q & (PI_A == REG_STATUS);
  assign sticky_clr    = rd_fall_q & (PI_A == REG_STATUS);

  assign full      = (count == CNT_W'(DEPTH));
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid & cmd_ready;
  // A pop in the same cycle frees a slot, so a push against a full
  // FIFO still lands when the head is leaving.
  assign push_ok   = push_req & (~full | pop);
  assign ovf_set   = push_req & full & ~pop;
  assign berr_set  = rsp_valid & rsp_berr;

  // Byte transfers pick one strobe from a0; word transfers assert both.
  always_comb begin
    new_cmd       = '0;
    new_cmd.addr  = {PI_D_in[7:0], addr_lo};
    new_cmd.data  = wdata;
    new_cmd.rw    = PI_D_in[9];
    new_cmd.fc    = PI_D_in[15:13];
    new_cmd.uds_n = PI_D_in[8] & a0;
    new_cmd.lds_n = PI_D_in[8] & ~a0;
  end

  assign head      = mem[rd_ptr];
  assign cmd_addr  = head.addr;
  assign cmd_data  = head.data;
  assign cmd_rw    = head.rw;
  assign cmd_uds_n = head.uds_n;
  assign cmd_lds_n = head.lds_n;
  assign cmd_fc    = head.fc;

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge c200m) begin
    if (push_ok) begin
      mem[wr_ptr] <= new_cmd;
    end
  end

  always_ff @(posedge c200m) begin
    if (rst) begin
      wr_sync     <= '0;
      rd_sync     <= '0;
      wr_rise_q   <= 1'b0;
      rd_fall_q   <= 1'b0;
      wdata       <= '0;
      addr_lo     <= '0;
      a0          <= 1'b0;
      ctrl_reg    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_pending  <= 1'b0;
      rd_data     <= '0;
      berr_sticky <= 1'b0;
      ovf_sticky  <= 1'b0;
      txn_q       <= 1'b0;
    end else begin
      wr_sync   <= {wr_sync[0], PI_WR};
      rd_sync   <= {rd_sync[0], PI_RD};
      wr_rise_q <= wr_sync[0] & ~wr_sync[1];
      rd_fall_q <= ~rd_sync[0] & rd_sync[1];

      if (wr_data_sel) begin
        wdata <= PI_D_in;
      end
      if (wr_lo_sel) begin
        addr_lo <= PI_D_in[15:1];
        a0      <= PI_D_in[0];
      end
      if (wr_status_sel) begin
        ctrl_reg <= PI_D_in;
      end

      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok & ~pop) begin
        count <= count + CNT_W'(1);
      end else if (pop & ~push_ok) begin
        count <= count - CNT_W'(1);
      end

      // A new read being queued keeps the pending flag up even if an
      // older cycle completes in the same clock.
      if (push_ok & new_cmd.rw) begin
        rd_pending <= 1'b1;
      end else if (rsp_valid) begin
        rd_pending <= 1'b0;
      end
      if (rsp_valid & rd_pending) begin
        rd_data <= rsp_data;
      end

      // Set beats clear so an event coinciding with the Pi's read is kept.
      berr_sticky <= berr_set | (berr_sticky & ~sticky_clr);
      ovf_sticky  <= ovf_set  | (ovf_sticky  & ~sticky_clr);

      txn_q <= cmd_valid | rd_pending | bus_busy;
    end
  end

  assign PI_TXN_IN_PROGRESS = txn_q;

  always_comb begin
    status_word              = '0;
    status_word[15:13]       = ipl;
    status_word[4 +: CNT_W]  = count;
    status_word[3]           = berr_sticky;
    status_word[2]           = ovf_sticky;
    status_word[1]           = full;
    status_word[0]           = txn_q;
  end

  assign PI_D_oe = PI_RD & ((PI_A == REG_DATA) | (PI_A == REG_STATUS));

  always_comb begin
    PI_D_out = '0;
    if (PI_D_oe) begin
      PI_D_out = (PI_A == REG_DATA) ? rd_data : status_word;
    end
  end

endmodule
